// File: rtl/uart_ctrl_sequencer_if.sv
// Receive-side byte bus from the UART receiver into the control sequencer.
// The receiver drives a one-cycle rx_ready strobe alongside the byte it qualifies.
interface uart_ctrl_sequencer_if;
    logic       rx_ready;
    logic [7:0] rx_byte;

    modport master (output rx_ready, output rx_byte);
    modport slave  (input  rx_ready, input  rx_byte);
endinterface

// File: rtl/uart_ctrl_sequencer.sv
// Parses framed UART commands (A5 CMD DATA CHK) into configuration registers,
// merges remote and local button pulses, and arbitrates NES-mode updates.
module uart_ctrl_sequencer #(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [4:0] DEFAULT_MULT   = 5'd1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_ctrl_sequencer_if.slave   rx,
    input  logic [7:0]             nes_in,
    input  logic                   use_nes_valid,
    input  logic                   use_nes_in,
    input  logic [7:0]             sw_in,
    output logic [7:0]             btn_out,
    output logic [4:0]             multiplier,
    output logic                   use_nes,
    output logic [7:0]             sw_out,
    output logic                   frame_ok,
    output logic                   frame_err,
    output logic [7:0]             err_count
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [1:0] {IDLE, GOT_SYNC, GOT_CMD, GOT_DATA} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    data_q, data_d;
    logic [4:0]    mult_q, mult_d;
    logic          use_nes_q, use_nes_d;
    logic [7:0]    ovr_q, ovr_d;
    logic          ovr_en_q, ovr_en_d;
    logic [7:0]    mask_q, mask_d;
    logic [7:0]    btn_q, btn_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          legal;
    logic          chk_good;

    always_comb begin
        case (cmd_q)
            8'h01:                      legal = (data_q[7:5] == 3'd0);
            8'h02, 8'h03, 8'h04, 8'h05: legal = 1'b1;
            default:                    legal = 1'b0;
        endcase
        chk_good = (rx.rx_byte == (SYNC ^ cmd_q ^ data_q));
    end

    // A byte always cancels a pending timeout because the rx_ready branch is taken first.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        mult_d    = mult_q;
        use_nes_d = use_nes_valid ? use_nes_in : use_nes_q;
        ovr_d     = ovr_q;
        ovr_en_d  = ovr_en_q;
        mask_d    = 8'd0;
        btn_d     = nes_in | mask_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if (rx.rx_ready) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (rx.rx_byte == SYNC) state_d = GOT_SYNC;
                end
                GOT_SYNC: begin
                    cmd_d   = rx.rx_byte;
                    state_d = GOT_CMD;
                end
                GOT_CMD: begin
                    data_d  = rx.rx_byte;
                    state_d = GOT_DATA;
                end
                default: begin
                    state_d = IDLE;
                    if (chk_good && legal) begin
                        ok_d = 1'b1;
                        case (cmd_q)
                            8'h01:   mult_d    = data_q[4:0];
                            8'h02:   use_nes_d = data_q[0];
                            8'h03:   mask_d    = data_q;
                            8'h04: begin
                                ovr_d    = data_q;
                                ovr_en_d = 1'b1;
                            end
                            default: ovr_en_d  = 1'b0;
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end

        if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= 8'd0;
            data_q    <= 8'd0;
            mult_q    <= DEFAULT_MULT;
            use_nes_q <= 1'b0;
            ovr_q     <= 8'd0;
            ovr_en_q  <= 1'b0;
            mask_q    <= 8'd0;
            btn_q     <= 8'd0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            mult_q    <= mult_d;
            use_nes_q <= use_nes_d;
            ovr_q     <= ovr_d;
            ovr_en_q  <= ovr_en_d;
            mask_q    <= mask_d;
            btn_q     <= btn_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign btn_out    = btn_q;
    assign multiplier = mult_q;
    assign use_nes    = use_nes_q;
    assign sw_out     = ovr_en_q ? ovr_q : sw_in;
    assign frame_ok   = ok_q;
    assign frame_err  = err_q;
    assign err_count  = err_cnt_q;
endmodule

// File: tb/tb_uart_ctrl_sequencer.sv
// Directed bench for uart_ctrl_sequencer: a frame-queue reference model is checked
// against the DUT on every falling edge, with literal checks pinning key results.
module tb_uart_ctrl_sequencer;
    localparam int TOUT = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] nes_in;
    logic       use_nes_valid;
    logic       use_nes_in;
    logic [7:0] sw_in;
    logic [7:0] btn_out;
    logic [4:0] multiplier;
    logic       use_nes;
    logic [7:0] sw_out;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] err_count;

    uart_ctrl_sequencer_if bus ();

    uart_ctrl_sequencer #(.TIMEOUT_CYCLES(TOUT), .DEFAULT_MULT(5'd1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (bus.slave),
        .nes_in        (nes_in),
        .use_nes_valid (use_nes_valid),
        .use_nes_in    (use_nes_in),
        .sw_in         (sw_in),
        .btn_out       (btn_out),
        .multiplier    (multiplier),
        .use_nes       (use_nes),
        .sw_out        (sw_out),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: collects bytes of the current frame in a queue and judges it once four arrive.
    logic [4:0] m_mult;
    logic       m_use_nes, m_ovr_en, m_ok, m_err;
    logic [7:0] m_ovr, m_btn, m_errcnt, m_mask;
    logic [7:0] m_frame[$];
    int         m_idle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mult = 5'd1; m_use_nes = 1'b0; m_ovr = 8'd0; m_ovr_en = 1'b0;
            m_btn = 8'd0; m_ok = 1'b0; m_err = 1'b0; m_errcnt = 8'd0; m_mask = 8'd0;
            m_frame.delete(); m_idle = 0;
        end else begin
            m_ok  = 1'b0;
            m_err = 1'b0;
            m_btn = nes_in | m_mask;
            m_mask = 8'd0;
            if (use_nes_valid) m_use_nes = use_nes_in;
            if (bus.rx_ready) begin
                m_idle = 0;
                if (m_frame.size() != 0 || bus.rx_byte == 8'hA5) m_frame.push_back(bus.rx_byte);
                if (m_frame.size() == 4) begin
                    logic [7:0] c, d;
                    bit ok;
                    c = m_frame[1];
                    d = m_frame[2];
                    ok = (m_frame[3] == (m_frame[0] ^ c ^ d));
                    if (c == 8'h01 && d > 8'd31) ok = 1'b0;
                    if (c < 8'h01 || c > 8'h05) ok = 1'b0;
                    if (ok) begin
                        m_ok = 1'b1;
                        if (c == 8'h01) m_mult = d[4:0];
                        if (c == 8'h02) m_use_nes = d[0];
                        if (c == 8'h03) m_mask = d;
                        if (c == 8'h04) begin m_ovr = d; m_ovr_en = 1'b1; end
                        if (c == 8'h05) m_ovr_en = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_frame.delete();
                end
            end else if (m_frame.size() != 0) begin
                m_idle++;
                if (m_idle == TOUT) begin
                    m_err = 1'b1;
                    m_frame.delete();
                    m_idle = 0;
                end
            end
            if (m_err && m_errcnt < 8'd255) m_errcnt = m_errcnt + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("btn_out",    32'(btn_out),    32'(m_btn));
            check_output("multiplier", 32'(multiplier), 32'(m_mult));
            check_output("use_nes",    32'(use_nes),    32'(m_use_nes));
            check_output("sw_out",     32'(sw_out),     32'(m_ovr_en ? m_ovr : sw_in));
            check_output("frame_ok",   32'(frame_ok),   32'(m_ok));
            check_output("frame_err",  32'(frame_err),  32'(m_err));
            check_output("err_count",  32'(err_count),  32'(m_errcnt));
        end
    end

    task automatic apply_stimulus(input logic rdy, input logic [7:0] b, input logic nv, input logic nval);
        @(posedge clk);
        #2;
        bus.rx_ready  = rdy;
        bus.rx_byte   = b;
        use_nes_valid = nv;
        use_nes_in    = nval;
        @(posedge clk);
        #2;
        bus.rx_ready  = 1'b0;
        use_nes_valid = 1'b0;
        use_nes_in    = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k,
                              input logic nv, input logic nval);
        apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        apply_stimulus(1'b1, c, 1'b0, 1'b0);
        apply_stimulus(1'b1, d, 1'b0, 1'b0);
        apply_stimulus(1'b1, k, nv, nval);
    endtask

    initial begin
        rst_n = 1'b1;
        bus.rx_ready = 1'b0; bus.rx_byte = 8'h00;
        nes_in = 8'h00; use_nes_valid = 1'b0; use_nes_in = 1'b0; sw_in = 8'h3C;
        #3 rst_n = 1'b0;
        #1;
        check_output("rst_mult",    32'(multiplier), 32'd1);
        check_output("rst_use_nes", 32'(use_nes),    32'd0);
        check_output("rst_btn",     32'(btn_out),    32'd0);
        check_output("rst_errcnt",  32'(err_count),  32'd0);
        check_output("rst_sw_out",  32'(sw_out),     32'h3C);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        apply_stimulus(1'b1, 8'h33, 1'b0, 1'b0);
        send_frame(8'h01, 8'h03, 8'hA7, 1'b0, 1'b0);
        @(negedge clk);
        check_output("mult_ok_pulse", 32'(frame_ok),   32'd1);
        check_output("mult_set",      32'(multiplier), 32'd3);
        check_output("stray_no_err",  32'(err_count),  32'd0);

        send_frame(8'h01, 8'hE3, 8'h47, 1'b0, 1'b0);
        @(negedge clk);
        check_output("mult_bad_err",  32'(frame_err),  32'd1);
        check_output("mult_kept",     32'(multiplier), 32'd3);
        check_output("errcnt_1",      32'(err_count),  32'd1);

        send_frame(8'h03, 8'h10, 8'hB6, 1'b0, 1'b0);
        nes_in = 8'h01;
        @(posedge clk);
        #2 nes_in = 8'h00;
        @(negedge clk);
        check_output("btn_merged",    32'(btn_out), 32'h11);
        @(negedge clk);
        check_output("btn_cleared",   32'(btn_out), 32'h00);

        send_frame(8'h04, 8'h5A, 8'hFB, 1'b0, 1'b0);
        sw_in = 8'hC3;
        @(negedge clk);
        check_output("ovr_on",        32'(sw_out), 32'h5A);
        send_frame(8'h05, 8'h00, 8'hA0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("ovr_off",       32'(sw_out), 32'hC3);

        send_frame(8'h02, 8'h01, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check_output("chk_bad_err",   32'(frame_err), 32'd1);
        check_output("chk_bad_nes",   32'(use_nes),   32'd0);
        check_output("errcnt_2",      32'(err_count), 32'd2);

        apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h02, 1'b0, 1'b0);
        repeat (TOUT + 2) @(negedge clk);
        check_output("timeout_err",   32'(err_count), 32'd3);
        send_frame(8'h02, 8'h01, 8'hA6, 1'b0, 1'b0);
        @(negedge clk);
        check_output("nes_set",       32'(use_nes), 32'd1);

        send_frame(8'h02, 8'h00, 8'hA7, 1'b1, 1'b1);
        @(negedge clk);
        check_output("arb_uart_wins", 32'(use_nes), 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        check_output("local_nes",     32'(use_nes), 32'd1);

        send_frame(8'h07, 8'h00, 8'hA2, 1'b0, 1'b0);
        @(negedge clk);
        check_output("illegal_cmd",   32'(err_count), 32'd4);

        apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h01, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_output("midrst_mult",   32'(multiplier), 32'd1);
        check_output("midrst_errcnt", 32'(err_count),  32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send_frame(8'h01, 8'h03, 8'hA7, 1'b0, 1'b0);
        @(negedge clk);
        check_output("post_rst_mult", 32'(multiplier), 32'd3);

        for (int i = 0; i < 256; i++) send_frame(8'h02, 8'h01, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_output("errcnt_sat",    32'(err_count), 32'd255);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
